// File: rtl/fifo_pkg.sv
// Shared sizing helpers and occupancy arithmetic for the single-clock FIFO.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 256;
  localparam int PTR_W     = $clog2(DEF_DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  // Pointer width for a given power-of-two depth.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Counter width: one extra bit so DEPTH itself is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Next occupancy; simultaneous accept or no accept leaves it unchanged.
  // Callers only assert wr_acc when not full and rd_acc when not empty.
  function automatic int unsigned next_count(input int unsigned count,
                                             input logic        wr_acc,
                                             input logic        rd_acc);
    case ({wr_acc, rd_acc})
      2'b10:   return count + 1;
      2'b01:   return count - 1;
      default: return count;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Latency: read data and its valid appear one cycle after i_rd_en.
// Backpressure: none; the controller only issues legal, non-colliding accesses.
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = ptr_w(DEPTH)
) (
  input  logic             i_wr_clk,
  input  logic             i_wr_dv,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_clk,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_dv
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store the word when the controller accepted it.
  always_ff @(posedge i_wr_clk) begin
    if (i_wr_dv) mem[i_wr_addr] <= i_wr_data;
  end

  // Read port: valid follows the request by one cycle; data held otherwise.
  always_ff @(posedge i_rd_clk) begin
    o_rd_dv <= i_rd_en;
    if (i_rd_en) o_rd_data <= mem[i_rd_addr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO controller wrapping the dual-port RAM (pointers, count, flags).
// Latency: read data valid one cycle after an accepted read; flags lag the causing edge by one.
// Backpressure: writes dropped while full (sticky o_ovf), reads ignored while empty (sticky o_udf).
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4,
  localparam int AW      = ptr_w(DEPTH),
  localparam int CW      = cnt_w(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_dv,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_full,
  output logic             o_af_flag,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_dv,
  output logic             o_empty,
  output logic             o_ae_flag,
  output logic [CW-1:0]    o_count,
  output logic             o_ovf,
  output logic             o_udf
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_acc;
  logic          rd_acc;
  logic [CW-1:0] cnt_nxt;

  // Acceptance uses the registered flags, i.e. state at the start of the cycle.
  assign wr_acc  = i_wr_dv & ~o_full  & ~i_rst;
  assign rd_acc  = i_rd_en & ~o_empty & ~i_rst;
  assign cnt_nxt = CW'(next_count(32'(o_count), wr_acc, rd_acc));

  // Pointers, occupancy, level flags and sticky error flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      o_count   <= '0;
      o_empty   <= 1'b1;
      o_full    <= 1'b0;
      o_ae_flag <= 1'b1;
      o_af_flag <= 1'b0;
      o_ovf     <= 1'b0;
      o_udf     <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      o_count   <= cnt_nxt;
      o_empty   <= (cnt_nxt == '0);
      o_full    <= (cnt_nxt == CW'(DEPTH));
      o_af_flag <= (cnt_nxt >= CW'(AF_LEVEL));
      o_ae_flag <= (cnt_nxt <= CW'(AE_LEVEL));
      o_ovf     <= o_ovf | (i_wr_dv & o_full);
      o_udf     <= o_udf | (i_rd_en & o_empty);
    end
  end

  sync_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_wr_clk  (i_clk),
    .i_wr_dv   (wr_acc),
    .i_wr_addr (wr_ptr),
    .i_wr_data (i_wr_data),
    .i_rd_clk  (i_clk),
    .i_rd_en   (rd_acc),
    .i_rd_addr (rd_ptr),
    .o_rd_data (o_rd_data),
    .o_rd_dv   (o_rd_dv)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo at DEPTH=8, AF_LEVEL=4, AE_LEVEL=2.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled there too.
// Backpressure: exercised through full/empty collisions and sticky error flags.
module tb_sync_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 4;
  localparam int AE    = 2;

  logic             clk;
  logic             rst;
  logic             wr_dv;
  logic [WIDTH-1:0] wr_data;
  logic             full;
  logic             af_flag;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_dv;
  logic             empty;
  logic             ae_flag;
  logic [3:0]       count;
  logic             ovf;
  logic             udf;

  int n_chk;
  int n_fail;

  sync_fifo #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_wr_dv   (wr_dv),
    .i_wr_data (wr_data),
    .o_full    (full),
    .o_af_flag (af_flag),
    .i_rd_en   (rd_en),
    .o_rd_data (rd_data),
    .o_rd_dv   (rd_dv),
    .o_empty   (empty),
    .o_ae_flag (ae_flag),
    .o_count   (count),
    .o_ovf     (ovf),
    .o_udf     (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_dv = 1'b0; rd_en = 1'b0; wr_data = '0;
    tick(); tick();
    n_chk++;
    if ({empty, full, count, rd_dv, ae_flag, af_flag, ovf, udf} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: empty=%b full=%b count=%0d rd_dv=%b ae=%b af=%b ovf=%b udf=%b, need 1 0 0 0 1 0 0 0",
               empty, full, count, rd_dv, ae_flag, af_flag, ovf, udf);
    end
    rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      wr_dv = 1'b1; wr_data = 8'h10 + 8'(i);
      tick();
      n_chk++;
      if ({count, full, af_flag, ae_flag, empty} !== {4'(i + 1), (i == 7), (i >= 3), (i <= 1), 1'b0}) begin
        n_fail++;
        $display("FAIL fill[%0d]: count=%0d full=%b af=%b ae=%b empty=%b, need %0d %b %b %b 0",
                 i, count, full, af_flag, ae_flag, empty, i + 1, (i == 7), (i >= 3), (i <= 1));
      end
    end
    wr_dv = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rd_en = 1'b1;
      tick();
      n_chk++;
      if ({rd_dv, rd_data, count} !== {1'b1, 8'h10 + 8'(k), 4'(7 - k)}) begin
        n_fail++;
        $display("FAIL drain[%0d]: rd_dv=%b data=%h count=%0d, need 1 %h %0d",
                 k, rd_dv, rd_data, count, 8'h10 + 8'(k), 7 - k);
      end
    end
    rd_en = 1'b0;
    n_chk++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_empty: empty=%b, need 1", empty);
    end
    tick();
    n_chk++;
    if (rd_dv !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_idle_dv: rd_dv=%b, need 0", rd_dv);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) begin
      wr_dv = 1'b1; wr_data = 8'h50 + 8'(i);
      tick();
    end
    wr_dv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    n_chk++;
    if ({rd_dv, rd_data, count} !== {1'b1, 8'h54, 4'd0}) begin
      n_fail++;
      $display("FAIL wrap_pre: rd_dv=%b data=%h count=%0d, need 1 54 0", rd_dv, rd_data, count);
    end
    for (int i = 0; i < 8; i++) begin
      wr_dv = 1'b1; wr_data = 8'hA0 + 8'(i);
      tick();
    end
    wr_dv = 1'b0;
    n_chk++;
    if ({count, full} !== {4'd8, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap_full: count=%0d full=%b, need 8 1", count, full);
    end
    for (int k = 0; k < 8; k++) begin
      rd_en = 1'b1;
      tick();
      n_chk++;
      if ({rd_dv, rd_data, count} !== {1'b1, 8'hA0 + 8'(k), 4'(7 - k)}) begin
        n_fail++;
        $display("FAIL wrap_read[%0d]: rd_dv=%b data=%h count=%0d, need 1 %h %0d",
                 k, rd_dv, rd_data, count, 8'hA0 + 8'(k), 7 - k);
      end
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 3; i++) begin
      wr_dv = 1'b1; wr_data = 8'hC0 + 8'(i);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      wr_dv = 1'b1; rd_en = 1'b1; wr_data = 8'hC3 + 8'(k);
      tick();
      n_chk++;
      if ({count, rd_dv, rd_data} !== {4'd3, 1'b1, 8'hC0 + 8'(k)}) begin
        n_fail++;
        $display("FAIL simul[%0d]: count=%0d rd_dv=%b data=%h, need 3 1 %h",
                 k, count, rd_dv, rd_data, 8'hC0 + 8'(k));
      end
    end
    wr_dv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rd_en = 1'b1;
      tick();
      n_chk++;
      if ({rd_dv, rd_data} !== {1'b1, 8'hC4 + 8'(k)}) begin
        n_fail++;
        $display("FAIL simul_drain[%0d]: rd_dv=%b data=%h, need 1 %h", k, rd_dv, rd_data, 8'hC4 + 8'(k));
      end
    end
    rd_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_dv = 1'b1; wr_data = 8'hD0 + 8'(i);
      tick();
    end
    n_chk++;
    if ({full, ovf} !== {1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL simul_full: full=%b ovf=%b, need 1 0", full, ovf);
    end
    wr_dv = 1'b1; rd_en = 1'b1; wr_data = 8'hEE;
    tick();
    n_chk++;
    if ({count, ovf, rd_dv, rd_data, full} !== {4'd7, 1'b1, 1'b1, 8'hD0, 1'b0}) begin
      n_fail++;
      $display("FAIL simul_at_full: count=%0d ovf=%b rd_dv=%b data=%h full=%b, need 7 1 1 d0 0",
               count, ovf, rd_dv, rd_data, full);
    end
    wr_dv = 1'b0;
    for (int k = 0; k < 7; k++) begin
      rd_en = 1'b1;
      tick();
      n_chk++;
      if ({rd_dv, rd_data} !== {1'b1, 8'hD1 + 8'(k)}) begin
        n_fail++;
        $display("FAIL simul_full_drain[%0d]: rd_dv=%b data=%h, need 1 %h", k, rd_dv, rd_data, 8'hD1 + 8'(k));
      end
    end
    n_chk++;
    if ({empty, udf} !== {1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL simul_empty: empty=%b udf=%b, need 1 0", empty, udf);
    end
    wr_dv = 1'b1; rd_en = 1'b1; wr_data = 8'hF1;
    tick();
    n_chk++;
    if ({count, udf, rd_dv, empty} !== {4'd1, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL simul_at_empty: count=%0d udf=%b rd_dv=%b empty=%b, need 1 1 0 0", count, udf, rd_dv, empty);
    end
    wr_dv = 1'b0;
    tick();
    rd_en = 1'b0;
    n_chk++;
    if ({rd_dv, rd_data, count} !== {1'b1, 8'hF1, 4'd0}) begin
      n_fail++;
      $display("FAIL simul_empty_word: rd_dv=%b data=%h count=%0d, need 1 f1 0", rd_dv, rd_data, count);
    end
  endtask

  task automatic test_over_under();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if ({ovf, udf} !== 2'b00) begin
      n_fail++;
      $display("FAIL ovf_udf_clear: ovf=%b udf=%b, need 0 0", ovf, udf);
    end
    for (int i = 0; i < 8; i++) begin
      wr_dv = 1'b1; wr_data = 8'h30 + 8'(i);
      tick();
    end
    wr_data = 8'h99;
    tick();
    wr_dv = 1'b0;
    n_chk++;
    if ({count, ovf, full} !== {4'd8, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL overflow: count=%0d ovf=%b full=%b, need 8 1 1", count, ovf, full);
    end
    tick(); tick();
    n_chk++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: ovf=%b, need 1", ovf);
    end
    for (int k = 0; k < 8; k++) begin
      rd_en = 1'b1;
      tick();
      n_chk++;
      if ({rd_dv, rd_data} !== {1'b1, 8'h30 + 8'(k)}) begin
        n_fail++;
        $display("FAIL ovf_drain[%0d]: rd_dv=%b data=%h, need 1 %h", k, rd_dv, rd_data, 8'h30 + 8'(k));
      end
    end
    n_chk++;
    if (udf !== 1'b0) begin
      n_fail++;
      $display("FAIL udf_early: udf=%b, need 0", udf);
    end
    tick();
    rd_en = 1'b0;
    n_chk++;
    if ({rd_dv, udf, count, empty} !== {1'b0, 1'b1, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL underflow: rd_dv=%b udf=%b count=%0d empty=%b, need 0 1 0 1", rd_dv, udf, count, empty);
    end
    tick(); tick(); tick();
    n_chk++;
    if ({udf, ovf} !== 2'b11) begin
      n_fail++;
      $display("FAIL udf_sticky: udf=%b ovf=%b, need 1 1", udf, ovf);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_dv = 1'b1; wr_data = 8'h60 + 8'(i);
      tick();
    end
    wr_dv = 1'b0;
    n_chk++;
    if (count !== 4'd5) begin
      n_fail++;
      $display("FAIL mid_count5: count=%0d, need 5", count);
    end
    rd_en = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    n_chk++;
    if ({rd_dv, rd_data, count} !== {1'b1, 8'h60, 4'd4}) begin
      n_fail++;
      $display("FAIL mid_inflight: rd_dv=%b data=%h count=%0d, need 1 60 4", rd_dv, rd_data, count);
    end
    tick();
    rst = 1'b0; rd_en = 1'b0;
    n_chk++;
    if ({count, empty, rd_dv, full, ae_flag} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_reset: count=%0d empty=%b rd_dv=%b full=%b ae=%b, need 0 1 0 0 1",
               count, empty, rd_dv, full, ae_flag);
    end
    wr_dv = 1'b1; wr_data = 8'h77;
    tick();
    wr_dv = 1'b0;
    n_chk++;
    if ({count, empty} !== {4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_fresh_wr: count=%0d empty=%b, need 1 0", count, empty);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_chk++;
    if ({rd_dv, rd_data, count} !== {1'b1, 8'h77, 4'd0}) begin
      n_fail++;
      $display("FAIL mid_fresh_rd: rd_dv=%b data=%h count=%0d, need 1 77 0", rd_dv, rd_data, count);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_over_under();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
